axistream_forwarder: RTL and testbench

AXISTREAM_FORWARDER -- requirements
Module: axistream_forwarder

---
 rtl/axistream_forwarder.sv | 184 ++++++++++++++++++
 tb/tb_axistream_forwarder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axistream_forwarder.sv
// Streams one packet at a time from the filter's packet memory onto AXI-Stream via a 2-entry skid buffer.
// Defining FWD_PKT_COUNT_EN adds a 32-bit pkt_count output counting forwarder_done pulses.
module axistream_forwarder #(
    parameter int unsigned SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH           = 64
) (
    input  logic                            axi_aclk,
    input  logic                            rst,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic                            forwarder_rd_en,
    input  logic [DATA_WIDTH-1:0]           forwarder_rd_data,
    output logic                            forwarder_done,
    input  logic                            ready_for_forwarder,
    input  logic [SNOOP_FWD_ADDR_WIDTH:0]   len_to_forwarder,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready
`ifdef FWD_PKT_COUNT_EN
    ,
    output logic [31:0]                     pkt_count
`endif
);

    localparam int unsigned PLEN_WIDTH = SNOOP_FWD_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [PLEN_WIDTH-1:0]           r_len;
    logic [PLEN_WIDTH-1:0]           r_rd_cnt;
    logic [SNOOP_FWD_ADDR_WIDTH-1:0] r_rd_addr;
    logic                            r_ign_ready;
    logic                            r_pend;
    logic                            r_pend_last;
    logic                            r_tvalid;
    logic [DATA_WIDTH-1:0]           r_tdata;
    logic                            r_tlast;
    logic                            r_skid_valid;
    logic [DATA_WIDTH-1:0]           r_skid_data;
    logic                            r_skid_last;

    logic                            w_hs;
    logic                            w_start;
    logic                            w_rd_en;
    logic                            w_done;
    logic                            w_credit_ok;
    logic                            w_rd_is_last;
    logic [1:0]                      w_occ;
    logic [PLEN_WIDTH-1:0]           w_rd_cnt_inc;

    assign w_hs         = r_tvalid & m_axis_tready;
    assign w_start      = (r_state == StIdle) & ready_for_forwarder & ~r_ign_ready;
    assign w_rd_cnt_inc = r_rd_cnt + PLEN_WIDTH'(1);
    assign w_rd_is_last = (w_rd_cnt_inc == r_len);

    // Words in flight plus buffered; a handshake this cycle frees one slot.
    assign w_occ       = 2'(r_pend) + 2'(r_tvalid) + 2'(r_skid_valid);
    assign w_credit_ok = (w_occ - 2'(w_hs)) < 2'd2;

    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = (len_to_forwarder == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (w_rd_en && w_rd_is_last) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_hs && r_tlast) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        w_rd_en = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            StRead:  w_rd_en = w_credit_ok;
            StDone:  w_done  = 1'b1;
            default: ;
        endcase
    end

    // Read side: length latch, full-width read counter and memory address.
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_rd_cnt    <= '0;
            r_rd_addr   <= '0;
            r_ign_ready <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            // Blocks a stale ready from restarting the engine right after DONE.
            r_ign_ready <= (r_state == StDone);
            if (w_start) begin
                r_len     <= len_to_forwarder;
                r_rd_cnt  <= '0;
                r_rd_addr <= '0;
            end else if (w_rd_en) begin
                r_rd_cnt  <= w_rd_cnt_inc;
                r_rd_addr <= r_rd_addr + SNOOP_FWD_ADDR_WIDTH'(1);
            end
            r_pend      <= w_rd_en;
            r_pend_last <= w_rd_en & w_rd_is_last;
        end
    end

    // Output register plus one skid entry; read data lands unconditionally.
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tlast      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
        end else if (!r_tvalid || w_hs) begin
            if (r_skid_valid) begin
                r_tvalid     <= 1'b1;
                r_tdata      <= r_skid_data;
                r_tlast      <= r_skid_last;
                r_skid_valid <= r_pend;
                r_skid_data  <= forwarder_rd_data;
                r_skid_last  <= r_pend_last;
            end else begin
                r_tvalid <= r_pend;
                r_tlast  <= r_pend & r_pend_last;
                if (r_pend) begin
                    r_tdata <= forwarder_rd_data;
                end
            end
        end else if (r_pend) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= forwarder_rd_data;
            r_skid_last  <= r_pend_last;
        end
    end

    assign forwarder_rd_addr = r_rd_addr;
    assign forwarder_rd_en   = w_rd_en;
    assign forwarder_done    = w_done;
    assign m_axis_tvalid     = r_tvalid;
    assign m_axis_tdata      = r_tdata;
    assign m_axis_tlast      = r_tlast;

`ifdef FWD_PKT_COUNT_EN
    logic [31:0] r_pkt_count;

    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            r_pkt_count <= '0;
        end else if (w_done) begin
            r_pkt_count <= r_pkt_count + 32'd1;
        end
    end

    assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_axistream_forwarder.sv
// Bench for axistream_forwarder: transaction-level model checked every cycle plus directed packets.
module tb_axistream_forwarder;
    localparam int AW    = 9;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          done;
    logic          ready = 1'b0;
    logic [AW:0]   len_in = '0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready = 1'b1;
`ifdef FWD_PKT_COUNT_EN
    logic [31:0]   pkt_count;
`endif

    axistream_forwarder #(
        .SNOOP_FWD_ADDR_WIDTH (AW),
        .DATA_WIDTH           (DW)
    ) dut (
        .axi_aclk            (clk),
        .rst                 (rst),
        .forwarder_rd_addr   (rd_addr),
        .forwarder_rd_en     (rd_en),
        .forwarder_rd_data   (rd_data),
        .forwarder_done      (done),
        .ready_for_forwarder (ready),
        .len_to_forwarder    (len_in),
        .m_axis_tdata        (tdata),
        .m_axis_tvalid       (tvalid),
        .m_axis_tlast        (tlast),
        .m_axis_tready       (tready)
`ifdef FWD_PKT_COUNT_EN
        ,
        .pkt_count           (pkt_count)
`endif
    );

    initial forever #5 clk = ~clk;

    // Filter packet memory: data valid the cycle after the read strobe.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model state: expected beats, read bookkeeping, done timing, ready-blocking window.
    int          cyc = 0;
    logic [63:0] q_data[$];
    bit          q_last[$];
    bit          m_busy = 0;
    int          m_len = 0, m_next_addr = 0, m_reads = 0, m_beats = 0;
    int          m_block_until = -10, m_done_cycle = -1, m_pkt_cnt = 0, n_done = 0;
    bit          prev_tv = 0, prev_tr = 0, prev_last = 0;
    logic [63:0] prev_data = '0;
    int          st_acc = -1, st_first_rd = -1, st_first_tv = -1, st_last_hs = -1, st_done = -1;
    int          st_beats = 0, st_reads = 0, st_stalls = 0;
    logic [63:0] st_last_data = '0;
    int          acc_log[$];
    int          done_log[$];

    initial begin
        logic [63:0] exp_d;
        bit          exp_l;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check("rst_ctrl", 64'({rd_addr, rd_en, done, tvalid, tlast}), 64'd0);
                check("rst_tdata", tdata, 64'd0);
`ifdef FWD_PKT_COUNT_EN
                check("rst_pkt_count", 64'(pkt_count), 64'd0);
`endif
                q_data.delete();
                q_last.delete();
                m_busy = 0; m_next_addr = 0; m_reads = 0; m_beats = 0;
                m_block_until = -10; m_done_cycle = -1; m_pkt_cnt = 0; prev_tv = 0;
            end else begin
`ifdef FWD_PKT_COUNT_EN
                check("pkt_count", 64'(pkt_count), 64'(m_pkt_cnt));
`endif
                check("done", 64'(done), 64'(cyc == m_done_cycle));
                if (cyc == m_done_cycle) begin
                    check("reads_at_done", 64'(m_reads), 64'(m_len));
                    n_done++; m_pkt_cnt++;
                    st_done = cyc;
                    done_log.push_back(cyc);
                    m_busy = 0;
                    m_block_until = cyc + 1;
                end
                if (prev_tv && !prev_tr) begin
                    check("stall_tvalid", 64'(tvalid), 64'd1);
                    check("stall_tdata", tdata, prev_data);
                    check("stall_tlast", 64'(tlast), 64'(prev_last));
                end
                check("rd_addr", 64'(rd_addr), 64'(m_next_addr % DEPTH));
                if (rd_en) begin
                    check("rd_en_allowed", 64'(m_busy && m_reads < m_len), 64'd1);
                    if (st_first_rd < 0) st_first_rd = cyc;
                    m_reads++; m_next_addr++; st_reads++;
                end
                check("spurious_tvalid", 64'(tvalid && q_data.size() == 0), 64'd0);
                if (tvalid && st_first_tv < 0) st_first_tv = cyc;
                if (tvalid && !tready) st_stalls++;
                if (tvalid && tready && q_data.size() > 0) begin
                    exp_d = q_data.pop_front();
                    exp_l = q_last.pop_front();
                    check("beat_data", tdata, exp_d);
                    check("beat_last", 64'(tlast), 64'(exp_l));
                    m_beats++; st_beats++;
                    st_last_data = tdata;
                    if (exp_l) begin
                        m_done_cycle = cyc + 1;
                        st_last_hs = cyc;
                    end
                end
                if (m_busy) check("outstanding_le2", 64'((m_reads - m_beats) <= 2), 64'd1);
                if (!m_busy && cyc > m_block_until && ready) begin
                    m_busy = 1; m_len = int'(len_in); m_next_addr = 0; m_reads = 0; m_beats = 0;
                    for (int i = 0; i < m_len; i++) begin
                        q_data.push_back(mem[i]);
                        q_last.push_back(i == m_len - 1);
                    end
                    st_acc = cyc; st_first_rd = -1; st_first_tv = -1; st_last_hs = -1;
                    st_done = -1; st_beats = 0; st_reads = 0; st_stalls = 0;
                    acc_log.push_back(cyc);
                    if (m_len == 0) m_done_cycle = cyc + 1;
                end
                prev_tv = tvalid; prev_tr = tready; prev_data = tdata; prev_last = tlast;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt(input int len);
        tick();
        ready  = 1'b1;
        len_in = (AW + 1)'(len);
        tick();
        ready  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit toggle);
        int n0 = n_done;
        int k  = 0;
        while (n_done == n0 && k < budget) begin
            tick();
            if (toggle) tready = ~tready;
            k++;
        end
        tready = 1'b1;
        if (n_done == n0) check({name, "_timeout"}, 64'd0, 64'd1);
        repeat (3) tick();
    endtask

    initial begin
        int n0;
        int a0;
        int seen;
        bit hit;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("after_rst_idle", 64'({tvalid, rd_en, done}), 64'd0);

        // Length 4, tready high: latency and back-to-back beats.
        for (int i = 0; i < 4; i++) mem[i] = 64'hA0 + 64'(i);
        start_pkt(4);
        wait_done("t1", 40, 0);
        check("t1_first_rd", 64'(st_first_rd - st_acc), 64'd1);
        check("t1_first_tv", 64'(st_first_tv - st_acc), 64'd3);
        check("t1_beats", 64'(st_beats), 64'd4);
        check("t1_no_bubble", 64'(st_last_hs - st_first_tv), 64'd3);
        check("t1_done_lat", 64'(st_done - st_last_hs), 64'd1);
        check("t1_last_data", st_last_data, 64'hA3);

        // Length 6 with tready toggling.
        for (int i = 0; i < 6; i++) mem[i] = 64'hB0 + 64'(i);
        start_pkt(6);
        wait_done("t2", 60, 1);
        check("t2_beats", 64'(st_beats), 64'd6);
        check("t2_last_data", st_last_data, 64'hB5);
        check("t2_stalled", 64'(st_stalls > 0), 64'd1);
        check("t2_done_lat", 64'(st_done - st_last_hs), 64'd1);

        // Length 1 and length 0.
        mem[0] = 64'hC0;
        start_pkt(1);
        wait_done("t3", 30, 0);
        check("t3_beats", 64'(st_beats), 64'd1);
        check("t3_last_data", st_last_data, 64'hC0);
        check("t3_first_tv", 64'(st_first_tv - st_acc), 64'd3);
        check("t3_done_lat", 64'(st_done - st_last_hs), 64'd1);
        start_pkt(0);
        wait_done("t4", 30, 0);
        check("t4_done_lat", 64'(st_done - st_acc), 64'd1);
        check("t4_reads", 64'(st_reads), 64'd0);
        check("t4_beats", 64'(st_beats), 64'd0);

        // Maximum length packet.
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'hD000_0000 + 64'(i);
        start_pkt(DEPTH);
        wait_done("t5", DEPTH + 40, 0);
        check("t5_reads", 64'(st_reads), 64'(DEPTH));
        check("t5_beats", 64'(st_beats), 64'(DEPTH));
        check("t5_last_data", st_last_data, 64'hD000_01FF);
        check("t5_no_bubble", 64'(st_last_hs - st_first_tv), 64'(DEPTH - 1));

        // Reset while beat 3 of 8 is on the bus.
        for (int i = 0; i < 8; i++) mem[i] = 64'hE0 + 64'(i);
        n0 = n_done;
        start_pkt(8);
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            tick();
            if (st_beats == 2) begin
                rst = 1'b1;
                hit = 1;
            end
        end
        check("t6_reached_beat3", 64'(hit), 64'd1);
        #1;
        check("t6_rst_immediate", 64'({tvalid, tlast, rd_en, done}), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        check("t6_no_done", 64'(n_done - n0), 64'd0);
        mem[0] = 64'hF0;
        mem[1] = 64'hF1;
        start_pkt(2);
        wait_done("t6b", 30, 0);
        check("t6b_beats", 64'(st_beats), 64'd2);
        check("t6b_last_data", st_last_data, 64'hF1);

        // Back-to-back packets with ready held high.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) mem[i] = 64'h70 + 64'(i);
        n0 = n_done;
        a0 = acc_log.size();
        ready  = 1'b1;
        len_in = (AW + 1)'(3);
        seen = 0;
        for (int k = 0; k < 60 && seen < 2; k++) begin
            tick();
            if (done) seen++;
        end
        ready = 1'b0;
        repeat (3) tick();
        check("t7_dones", 64'(n_done - n0), 64'd2);
        check("t7_accepts", 64'(acc_log.size() - a0), 64'd2);
        if (acc_log.size() - a0 == 2 && done_log.size() >= 2)
            check("t7_resample_gap",
                  64'(acc_log[acc_log.size() - 1] - done_log[done_log.size() - 2]), 64'd2);
`ifdef FWD_PKT_COUNT_EN
        check("t7_pkt_count", 64'(pkt_count), 64'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
